uart_buffered_tx: RTL and testbench

- Synthesizable 8N1 UART transmitter with an internal write FIFO.
- Drives OUT_SERIAL_TX of the top-level design and is the transmit end of the serial terminal link.
- Core logic pushes bytes with a single-cycle strobe. The block serializes them back-to-back at a fixed baud derived from CLK (25 MHz system clock, 40 ns period).

---
 rtl/uart_buffered_tx.sv | 147 ++++++++++++++
 tb/tb_uart_buffered_tx.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/uart_buffered_tx.sv
`timescale 1ns/1ps
// 8N1 UART transmitter fed by a circular write FIFO.
// Queued bytes are serialized back-to-back with no idle gap between frames.
module uart_buffered_tx #(
    parameter int CLKS_PER_BIT   = 217,
    parameter int FIFO_ADDR_BITS = 4
) (
    input  logic                      CLK,
    input  logic                      RESET,
    input  logic [7:0]                IN_DATA,
    input  logic                      IN_WRITE,
    output logic                      OUT_FULL,
    output logic                      OUT_EMPTY,
    output logic [FIFO_ADDR_BITS:0]   OUT_COUNT,
    output logic                      OUT_OVERFLOW,
    output logic                      OUT_BUSY,
    output logic                      OUT_SERIAL_TX
);
    localparam int          DEPTH    = 1 << FIFO_ADDR_BITS;
    localparam logic [15:0] BIT_LAST = 16'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    logic [7:0]                mem_q [DEPTH];
    logic [FIFO_ADDR_BITS-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [FIFO_ADDR_BITS:0]   count_q, count_d;
    logic                      full_q, full_d, empty_q, empty_d;
    logic                      overflow_q, overflow_d;
    logic                      push, pop;

    state_t      state_q, state_d;
    logic [15:0] timer_q, timer_d;
    logic [2:0]  bit_idx_q, bit_idx_d;
    logic [7:0]  shift_q, shift_d;
    logic        tx_q, tx_d;
    logic        bit_done;

    // Accept/drop decisions use pre-edge full_q, so a same-edge pop never rescues a write.
    always_comb begin
        push       = IN_WRITE && !full_q;
        overflow_d = IN_WRITE && full_q;
        wr_ptr_d   = wr_ptr_q + FIFO_ADDR_BITS'(push);
        rd_ptr_d   = rd_ptr_q + FIFO_ADDR_BITS'(pop);
        count_d    = count_q + (FIFO_ADDR_BITS+1)'(push) - (FIFO_ADDR_BITS+1)'(pop);
        full_d     = (count_d == (FIFO_ADDR_BITS+1)'(DEPTH));
        empty_d    = (count_d == '0);
    end

    assign bit_done = (timer_q == BIT_LAST);

    always_comb begin
        state_d   = state_q;
        timer_d   = timer_q + 16'd1;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        tx_d      = tx_q;
        pop       = 1'b0;
        case (state_q)
            IDLE: begin
                timer_d = '0;
                tx_d    = 1'b1;
                if (!empty_q) begin
                    pop     = 1'b1;
                    shift_d = mem_q[rd_ptr_q];
                    state_d = START;
                    tx_d    = 1'b0;
                end
            end
            START: begin
                if (bit_done) begin
                    timer_d   = '0;
                    bit_idx_d = '0;
                    state_d   = DATA;
                    tx_d      = shift_q[0];
                end
            end
            DATA: begin
                if (bit_done) begin
                    timer_d = '0;
                    if (bit_idx_q == 3'd7) begin
                        state_d = STOP;
                        tx_d    = 1'b1;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                        shift_d   = {1'b0, shift_q[7:1]};
                        tx_d      = shift_q[1];
                    end
                end
            end
            STOP: begin
                if (bit_done) begin
                    timer_d = '0;
                    // Chain straight into the next start bit when data is waiting.
                    if (!empty_q) begin
                        pop     = 1'b1;
                        shift_d = mem_q[rd_ptr_q];
                        state_d = START;
                        tx_d    = 1'b0;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            full_q     <= 1'b0;
            empty_q    <= 1'b1;
            overflow_q <= 1'b0;
            state_q    <= IDLE;
            timer_q    <= '0;
            bit_idx_q  <= '0;
            shift_q    <= '0;
            tx_q       <= 1'b1;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            full_q     <= full_d;
            empty_q    <= empty_d;
            overflow_q <= overflow_d;
            state_q    <= state_d;
            timer_q    <= timer_d;
            bit_idx_q  <= bit_idx_d;
            shift_q    <= shift_d;
            tx_q       <= tx_d;
        end
    end

    // Storage needs no reset; pointers define what is valid.
    always_ff @(posedge CLK) begin
        if (push) mem_q[wr_ptr_q] <= IN_DATA;
    end

    assign OUT_FULL      = full_q;
    assign OUT_EMPTY     = empty_q;
    assign OUT_COUNT     = count_q;
    assign OUT_OVERFLOW  = overflow_q;
    assign OUT_BUSY      = (state_q != IDLE);
    assign OUT_SERIAL_TX = tx_q;
endmodule

// File: tb/tb_uart_buffered_tx.sv
`timescale 1ns/1ps
// Scoreboard bench: stimulus queues expected bytes, serial monitors decode the line and compare.
module tb_uart_buffered_tx;
    localparam int CPB0 = 4;
    localparam int CPB1 = 217;

    logic clk = 1'b0;
    always #20 clk = ~clk;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic       rst0, wr0, full0, empty0, ovf0, busy0, tx0;
    logic       rst1, wr1, full1, empty1, ovf1, busy1, tx1;
    logic [7:0] din0, din1;
    logic [4:0] cnt0, cnt1;

    uart_buffered_tx #(.CLKS_PER_BIT(CPB0), .FIFO_ADDR_BITS(4)) u0 (
        .CLK(clk), .RESET(rst0), .IN_DATA(din0), .IN_WRITE(wr0),
        .OUT_FULL(full0), .OUT_EMPTY(empty0), .OUT_COUNT(cnt0),
        .OUT_OVERFLOW(ovf0), .OUT_BUSY(busy0), .OUT_SERIAL_TX(tx0));

    uart_buffered_tx #(.CLKS_PER_BIT(CPB1), .FIFO_ADDR_BITS(4)) u1 (
        .CLK(clk), .RESET(rst1), .IN_DATA(din1), .IN_WRITE(wr1),
        .OUT_FULL(full1), .OUT_EMPTY(empty1), .OUT_COUNT(cnt1),
        .OUT_OVERFLOW(ovf1), .OUT_BUSY(busy1), .OUT_SERIAL_TX(tx1));

    int         checks = 0;
    int         failures = 0;
    logic [7:0] exp0[$];
    logic [7:0] exp1[$];
    int         starts0[$];
    int         peak0 = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
        end
    endtask

    // Mid-bit sampling decoder; any frame it completes is matched against the queue.
    task automatic monitor(input int id, input int cpb);
        int         ph;
        int         h;
        logic [7:0] b;
        logic [7:0] e;
        logic       tx;
        logic       rst;
        ph = -1;
        h  = cpb / 2;
        b  = '0;
        forever begin
            @(posedge clk); #2;
            tx  = (id == 0) ? tx0 : tx1;
            rst = (id == 0) ? rst0 : rst1;
            if (rst) ph = -1;
            else if (ph < 0) begin
                if (tx == 1'b0) begin
                    ph = 0;
                    if (id == 0) starts0.push_back(cyc);
                end
            end else ph++;
            if (ph >= 0) begin
                if (ph == h) chk($sformatf("mon%0d_start_bit", id), tx, 0);
                else if (ph == h + 9*cpb) begin
                    chk($sformatf("mon%0d_stop_bit", id), tx, 1);
                    if ((id == 0 && exp0.size() == 0) || (id == 1 && exp1.size() == 0)) begin
                        checks++;
                        failures++;
                        $display("FAIL mon%0d_unexpected_frame actual=0x%0h required=none", id, b);
                    end else begin
                        e = (id == 0) ? exp0.pop_front() : exp1.pop_front();
                        chk($sformatf("mon%0d_byte", id), b, e);
                    end
                end else if (ph > h && ((ph - h) % cpb) == 0) b[(ph - h) / cpb - 1] = tx;
                if (ph == 10*cpb - 1) ph = -1;
            end
        end
    endtask

    initial monitor(0, CPB0);
    initial monitor(1, CPB1);

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic push0(input logic [7:0] d, input bit expect_ok);
        din0 = d;
        wr0  = 1'b1;
        if (expect_ok) exp0.push_back(d);
        tick();
        wr0 = 1'b0;
        if (cnt0 > peak0) peak0 = cnt0;
    endtask

    task automatic wait_idle(input int id, input int budget, input string name);
        int n;
        n = 0;
        while (n < budget && ((id == 0) ? (exp0.size() != 0 || busy0 || !empty0)
                                        : (exp1.size() != 0 || busy1 || !empty1))) begin
            tick();
            n++;
            if (id == 0 && cnt0 > peak0) peak0 = cnt0;
        end
        chk({name, "_drain_in_budget"}, n < budget, 1);
    endtask

    initial begin
        int         bad, busy_n, ovf_n, d, p;
        logic [9:0] frame;
        logic [7:0] msg [4];
        rst0 = 1'b1; rst1 = 1'b1; wr0 = 1'b0; wr1 = 1'b0; din0 = '0; din1 = '0;
        tick(); tick();
        chk("reset_tx", tx0, 1);
        chk("reset_busy", busy0, 0);
        chk("reset_full", full0, 0);
        chk("reset_empty", empty0, 1);
        chk("reset_count", cnt0, 0);
        chk("reset_overflow", ovf0, 0);
        rst0 = 1'b0; rst1 = 1'b0;
        tick();

        // Single byte: exact waveform and busy length.
        push0(8'h55, 1);
        chk("t1_empty_after_push", empty0, 0);
        chk("t1_count_after_push", cnt0, 1);
        chk("t1_tx_still_idle", tx0, 1);
        tick();
        chk("t1_tx_start", tx0, 0);
        chk("t1_busy_start", busy0, 1);
        chk("t1_empty_after_pop", empty0, 1);
        frame = {1'b1, 8'h55, 1'b0};
        bad = 0; busy_n = 0;
        for (int j = 0; j < 40; j++) begin
            if (tx0 !== frame[j / 4]) bad++;
            if (busy0) busy_n++;
            tick();
        end
        chk("t1_wave_mismatches", bad, 0);
        chk("t1_busy_cycles", busy_n, 40);
        chk("t1_busy_end", busy0, 0);
        chk("t1_tx_end", tx0, 1);
        wait_idle(0, 200, "t1");

        // Three bytes back to back.
        starts0.delete();
        peak0 = 0;
        push0(8'h41, 1);
        chk("t2_count_a", cnt0, 1);
        push0(8'h42, 1);
        chk("t2_count_b", cnt0, 1);
        push0(8'h0D, 1);
        chk("t2_count_cr", cnt0, 2);
        wait_idle(0, 300, "t2");
        chk("t2_peak_count", peak0, 2);
        chk("t2_frames", starts0.size(), 3);
        if (starts0.size() == 3) begin
            chk("t2_gap_ab", starts0[1] - starts0[0], 40);
            chk("t2_gap_bcr", starts0[2] - starts0[1], 40);
        end

        // Fill while busy, overflow, then full + pop + write on the same edge.
        push0(8'hEE, 1);
        d = cyc;
        tick(); tick();
        ovf_n = 0;
        for (int i = 0; i < 17; i++) begin
            push0(i[7:0], i < 16);
            if (ovf0) ovf_n++;
        end
        chk("t3_full", full0, 1);
        chk("t3_count", cnt0, 16);
        while (cyc < d + 40) begin
            tick();
            if (ovf0) ovf_n++;
        end
        chk("t3_overflow_pulses", ovf_n, 1);
        chk("t3_count_before_pop", cnt0, 16);
        push0(8'h99, 0);
        chk("t4_overflow", ovf0, 1);
        chk("t4_count", cnt0, 15);
        chk("t4_full_cleared", full0, 0);
        chk("t4_next_start", tx0, 0);
        tick();
        chk("t4_overflow_one_cycle", ovf0, 0);
        wait_idle(0, 1000, "t3");

        // Reset in the middle of data bit 3 with bytes still queued.
        push0(8'hA5, 1);
        p = cyc;
        for (int i = 0; i < 5; i++) push0(8'h11 + i[7:0], 1);
        chk("t5_count_queued", cnt0, 5);
        while (cyc < p + 17) tick();
        chk("t5_bit3_value", tx0, 0);
        rst0 = 1'b1;
        tick();
        exp0.delete();
        chk("t5_reset_tx", tx0, 1);
        chk("t5_reset_busy", busy0, 0);
        chk("t5_reset_empty", empty0, 1);
        chk("t5_reset_count", cnt0, 0);
        rst0 = 1'b0;
        bad = 0;
        for (int j = 0; j < 60; j++) begin
            tick();
            if (tx0 !== 1'b1 || busy0 !== 1'b0) bad++;
        end
        chk("t5_quiet_after_reset", bad, 0);
        push0(8'h3C, 1);
        wait_idle(0, 200, "t5");

        // Real baud divisor: "OK\r\n".
        msg[0] = 8'h4F; msg[1] = 8'h4B; msg[2] = 8'h0D; msg[3] = 8'h0A;
        for (int i = 0; i < 4; i++) begin
            din1 = msg[i];
            wr1  = 1'b1;
            exp1.push_back(msg[i]);
            tick();
            wr1 = 1'b0;
        end
        chk("t6_count_queued", cnt1, 3);
        wait_idle(1, 10000, "t6");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #(40 * 50000);
        failures++;
        $display("FAIL watchdog actual=timeout required=finish");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end
endmodule
